// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle for alu_op_sequencer.
// master = requester/consumer side, slave = sequencer side.
interface alu_op_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_op;
  logic       req_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_zero;

  modport master (
    output req_valid,
    input  req_ready,
    output req_a,
    output req_b,
    output req_op,
    output req_acc,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_result,
    input  rsp_zero
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_a,
    input  req_b,
    input  req_op,
    input  req_acc,
    output rsp_valid,
    input  rsp_ready,
    output rsp_result,
    output rsp_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequential front end for the 4-bit combinational ALU with accumulator.
// Optional op counter enabled by macro ALU_SEQ_OPCOUNT_EN.
module alu_op_sequencer (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.slave    bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_opcode,
  input  logic [3:0]           alu_result,
  output logic [7:0]           op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic [3:0] rsp_result_q;
  logic       rsp_zero_q;
  logic [3:0] acc_q;

  logic req_fire;
  logic rsp_fire;

  // Handshake status comes only from the state register.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);

  assign req_fire = bus.req_valid && (state_q == IDLE);
  assign rsp_fire = bus.rsp_ready && (state_q == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= 4'h0;
      alu_b_q      <= 4'h0;
      alu_op_q     <= 3'h0;
      rsp_result_q <= 4'h0;
      rsp_zero_q   <= 1'b0;
      acc_q        <= 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            alu_a_q  <= bus.req_acc ? acc_q : bus.req_a;
            alu_b_q  <= bus.req_b;
            alu_op_q <= bus.req_op;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= (alu_result == 4'h0);
          acc_q        <= alu_result;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_fire) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_opcode     = alu_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

`ifdef ALU_SEQ_OPCOUNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'h00;
    end else if (rsp_fire) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign op_count = cnt_q;
`else
  assign op_count = 8'h00;
`endif

endmodule
